// File: rtl/ascon_stream_ctrl.sv
// ascon_stream_ctrl: host-side sequencer for the ASCON-128 core.
// Takes a session config, then feeds one block at a time through the core.
`timescale 1ns/1ps
module ascon_stream_ctrl #(
  parameter int RATE           = 64,
  parameter int KEY_WIDTH      = 128,
  parameter int NONCE_WIDTH    = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_mode,
  input  logic [KEY_WIDTH-1:0]   cfg_key,
  input  logic [NONCE_WIDTH-1:0] cfg_nonce,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RATE-1:0]        in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RATE-1:0]        out_data,
  output logic                   out_last,
  input  logic                   abort,
  output logic                   core_start,
  output logic                   core_mode,
  output logic [KEY_WIDTH-1:0]   core_key,
  output logic [NONCE_WIDTH-1:0] core_nonce,
  output logic [RATE-1:0]        core_data_in,
  input  logic [RATE-1:0]        core_data_out,
  input  logic                   core_done,
  output logic [15:0]            blk_count,
  output logic                   session_done,
  output logic                   err
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    START,
    WAIT,
    OUT
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [15:0]      tmo_cnt;
  logic             mode_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [NONCE_WIDTH-1:0] nonce_q;
  logic [RATE-1:0]  din_q;
  logic             last_q;

  logic cfg_fire;
  logic in_fire;
  logic done_fire;
  logic tmo_fire;
  logic out_fire;
  logic tmo_hit;

  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign done_fire = (state == WAIT) && core_done && !abort;
  assign tmo_fire  = (state == WAIT) && !core_done && tmo_hit && !abort;
  assign out_fire  = out_valid && out_ready && !abort;

  assign core_mode    = mode_q;
  assign core_key     = key_q;
  assign core_nonce   = nonce_q;
  assign core_data_in = din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = !abort;
        if (cfg_valid) state_nx = ACCEPT;
      end
      ACCEPT: begin
        in_ready = !abort;
        if (in_valid) state_nx = START;
      end
      START: begin
        core_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (core_done)    state_nx = OUT;
        else if (tmo_hit) state_nx = IDLE;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = out_last ? IDLE : ACCEPT;
      end
      default: state_nx = IDLE;
    endcase
    // abort beats every other transition and suppresses the start pulse
    if (abort) begin
      state_nx   = IDLE;
      core_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= 1'b0;
      key_q   <= '0;
      nonce_q <= '0;
      din_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      if (cfg_fire) begin
        mode_q  <= cfg_mode;
        key_q   <= cfg_key;
        nonce_q <= cfg_nonce;
      end
      if (in_fire) begin
        din_q  <= in_data;
        last_q <= in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == START) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data     <= '0;
      out_last     <= 1'b0;
      blk_count    <= '0;
      session_done <= 1'b0;
      err          <= 1'b0;
    end else begin
      session_done <= out_fire && out_last;
      if (cfg_fire) blk_count <= '0;
      if (done_fire) begin
        out_data  <= core_data_out;
        out_last  <= last_q;
        blk_count <= blk_count + 16'd1;
      end
      if (tmo_fire) err <= 1'b1;
    end
  end

endmodule
